// File: rtl/eq_band_sequencer_if.sv
// ---------------------------------------------------------------------------
// eq_band_sequencer_if
// Bundles the control-side write port, the sample strobe and the band-facing
// set/gain bus of the equalizer band sequencer.
//   i_wr, i_wr_band, i_wr_gain : gain write from the UI/control side
//   i_load_all                 : request to re-push the whole gain table
//   i_next                     : sample strobe as seen by the bands
//   o_set                      : one-hot set strobe per band
//   o_gain                     : shared signed gain bus (dB)
//   o_busy                     : sequencer has pending or in-flight work
// master drives the requests, slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface eq_band_sequencer_if #(
   parameter int NBAND = 8,
   parameter int BW    = 3
);
   logic                     i_wr;
   logic [BW-1:0]            i_wr_band;
   logic signed [15:0]       i_wr_gain;
   logic                     i_load_all;
   logic                     i_next;
   logic [NBAND-1:0]         o_set;
   logic signed [15:0]       o_gain;
   logic                     o_busy;

   modport master (
      output i_wr, i_wr_band, i_wr_gain, i_load_all, i_next,
      input  o_set, o_gain, o_busy
   );

   modport slave (
      input  i_wr, i_wr_band, i_wr_gain, i_load_all, i_next,
      output o_set, o_gain, o_busy
   );
endinterface

// File: rtl/eq_band_sequencer.sv
// ---------------------------------------------------------------------------
// eq_band_sequencer
// Owns the per-band gain table of the equalizer filter bank. Gain writes are
// clamped to [-GMAX, +GMAX] and mark their band dirty; dirty bands are pushed
// to the biquads one at a time, round-robin, and only while no sample is in
// flight. After each set pulse the gain bus is held for SET_GAP cycles so the
// band can finish its coefficient computation.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of eq_band_sequencer_if (write port, i_load_all,
//             i_next, o_set, o_gain, o_busy)
// ---------------------------------------------------------------------------
module eq_band_sequencer #(
   parameter int NBAND   = 8,
   parameter int BW      = 3,
   parameter int GMAX    = 12,
   parameter int SET_GAP = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   eq_band_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD
   } state_t;

   localparam logic signed [15:0] GAIN_HI  = 16'(GMAX);
   localparam logic signed [15:0] GAIN_LO  = 16'(-GMAX);
   localparam logic [7:0]         LAST_CNT = 8'(SET_GAP - 1);

   state_t                state_q, state_d;
   logic signed [15:0]    table_q [NBAND];
   logic signed [15:0]    table_d [NBAND];
   logic [NBAND-1:0]      dirty_q, dirty_d;
   logic [BW-1:0]         ptr_q, ptr_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [NBAND-1:0]      set_q, set_d;
   logic signed [15:0]    gain_q, gain_d;
   logic                  busy_q, busy_d;
   logic                  nextSeen_q;

   int                    bandIdx;
   int                    scanIdx;
   logic                  wrValid;
   logic signed [15:0]    wrGainClamped;
   logic                  selFound;
   logic [BW-1:0]         selIdx;
   logic                  holdDone;
   logic                  quiet;
   logic                  issueNow;

   // Decode the control-side write: drop out-of-range band indices and
   // saturate the requested gain with a signed compare.
   always_comb begin
      bandIdx = int'(bus.i_wr_band);
      wrValid = bus.i_wr && (bandIdx < NBAND);
      if (bus.i_wr_gain > GAIN_HI) begin
         wrGainClamped = GAIN_HI;
      end else if (bus.i_wr_gain < GAIN_LO) begin
         wrGainClamped = GAIN_LO;
      end else begin
         wrGainClamped = bus.i_wr_gain;
      end
   end

   // Round-robin pick: scan downward from the farthest offset so the last hit
   // kept is the first dirty band at or above the pointer, with wrap-around.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      scanIdx  = 0;
      for (int i = NBAND - 1; i >= 0; i--) begin
         scanIdx = int'(ptr_q) + i;
         if (scanIdx >= NBAND) begin
            scanIdx = scanIdx - NBAND;
         end
         if (dirty_q[scanIdx]) begin
            selFound = 1'b1;
            selIdx   = BW'(scanIdx);
         end
      end
   end

   // A new set may start from IDLE or straight out of the last HOLD cycle, so
   // back-to-back issues are spaced exactly 1 + SET_GAP cycles. The sample
   // strobe must be low now and on the previous cycle: this never starts a set
   // while a sample is in flight and leaves the bands one quiet cycle after it.
   always_comb begin
      holdDone = (state_q == HOLD) && (cnt_q == LAST_CNT);
      quiet    = !bus.i_next && !nextSeen_q;
      issueNow = selFound && quiet && ((state_q == IDLE) || holdDone);
   end

   // Next-state logic. A write landing on the band being issued in the same
   // cycle wins over the dirty clear, so that band goes out again later with
   // the new value while the current pulse carries the previously latched one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      set_d   = '0;
      gain_d  = gain_q;
      dirty_d = dirty_q;
      table_d = table_q;

      case (state_q)
         ISSUE: begin
            state_d = HOLD;
            cnt_d   = '0;
         end
         HOLD: begin
            if (holdDone) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
         end
      endcase

      if (issueNow) begin
         state_d         = ISSUE;
         set_d           = NBAND'(1) << selIdx;
         gain_d          = table_q[selIdx];
         dirty_d[selIdx] = 1'b0;
         if (int'(selIdx) == NBAND - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = selIdx + 1'b1;
         end
      end

      if (bus.i_load_all) begin
         dirty_d = '1;
      end

      if (wrValid) begin
         table_d[bandIdx] = wrGainClamped;
         dirty_d[bandIdx] = 1'b1;
      end

      busy_d = (|dirty_d) || (state_d != IDLE);
   end

   // All state and registered outputs. Reset aborts any issue in progress;
   // the bands' own reset already corresponds to 0 dB so nothing is re-sent.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < NBAND; i++) begin
            table_q[i] <= '0;
         end
         dirty_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         set_q      <= '0;
         gain_q     <= '0;
         busy_q     <= 1'b0;
         nextSeen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         table_q    <= table_d;
         dirty_q    <= dirty_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         set_q      <= set_d;
         gain_q     <= gain_d;
         busy_q     <= busy_d;
         nextSeen_q <= bus.i_next;
      end
   end

   assign bus.o_set  = set_q;
   assign bus.o_gain = gain_q;
   assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eq_band_sequencer
// Self-checking bench for eq_band_sequencer. An 8-band instance carries most
// scenarios; a 6-band instance covers out-of-range band indices. Expected set
// pulses are queued as stimulus is driven and popped by a monitor whenever
// the 8-band instance raises a set strobe.
// ---------------------------------------------------------------------------
module tb_eq_band_sequencer;

   localparam int GMAX = 12;

   typedef struct {
      int                 band;
      logic signed [15:0] gain;
   } expEntry_t;

   logic clock = 1'b0;
   logic rstN;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int pulseCount = 0;
   int pulseTimes[$];
   expEntry_t expQ[$];

   eq_band_sequencer_if #(.NBAND(8), .BW(3)) bus8 ();
   eq_band_sequencer_if #(.NBAND(6), .BW(3)) bus6 ();

   eq_band_sequencer #(.NBAND(8), .BW(3), .GMAX(GMAX), .SET_GAP(3)) dut8 (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .bus     (bus8)
   );

   eq_band_sequencer #(.NBAND(6), .BW(3), .GMAX(GMAX), .SET_GAP(3)) dut6 (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .bus     (bus6)
   );

   // Free-running clock and a cycle index that names each rising edge.
   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
   end

   // Scoreboard monitor: every observed set strobe must match the oldest
   // queued expectation in both band and gain.
   always @(negedge clock) begin
      expEntry_t  e;
      logic [7:0] expSet;
      if (bus8.o_set !== 8'b0) begin
         pulseCount++;
         pulseTimes.push_back(cyc);
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_pulse: o_set=%b o_gain=%0d, no pulse expected",
                     bus8.o_set, bus8.o_gain);
         end else begin
            e      = expQ.pop_front();
            expSet = 8'b1 << e.band;
            if (bus8.o_set !== expSet) begin
               mismatched++;
               $display("[TB] FAIL pulse_band: o_set=%b expected %b", bus8.o_set, expSet);
            end
            compared++;
            if (bus8.o_gain !== e.gain) begin
               mismatched++;
               $display("[TB] FAIL pulse_gain: band %0d o_gain=%0d expected %0d",
                        e.band, bus8.o_gain, e.gain);
            end
         end
      end
   end

   // Watchdog so the run always ends even if the DUT stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic signed [15:0] clampGain(input int g);
      if (g > GMAX) return 16'(GMAX);
      if (g < -GMAX) return 16'(-GMAX);
      return 16'(g);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expectPulse(input int band, input int gain);
      expEntry_t e;
      e.band = band;
      e.gain = clampGain(gain);
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input int band, input int gain);
      bus8.i_wr      = 1'b1;
      bus8.i_wr_band = 3'(band);
      bus8.i_wr_gain = 16'(gain);
      tick();
      bus8.i_wr      = 1'b0;
   endtask

   task automatic waitPulses(input int target, input int budget);
      int n = 0;
      while (pulseCount < target && n < budget) begin
         tick();
         n++;
      end
      compared++;
      if (pulseCount < target) begin
         mismatched++;
         $display("[TB] FAIL pulse_timeout: saw %0d pulses, required %0d", pulseCount, target);
      end
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (bus8.o_busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      compared++;
      if (bus8.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_timeout: o_busy=%b, required 0", bus8.o_busy);
      end
   endtask

   task automatic doReset();
      rstN = 1'b0;
      tick();
      tick();
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      tick();
      tick();
      compared++;
      if (bus8.o_set !== 8'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_set: o_set=%b required 0", bus8.o_set);
      end
      compared++;
      if (bus8.o_gain !== 16'sd0) begin
         mismatched++;
         $display("[TB] FAIL reset_gain: o_gain=%0d required 0", bus8.o_gain);
      end
      compared++;
      if (bus8.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_busy: o_busy=%b required 0", bus8.o_busy);
      end
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      int t;
      expectPulse(2, 6);
      bus8.i_wr      = 1'b1;
      bus8.i_wr_band = 3'd2;
      bus8.i_wr_gain = 16'sd6;
      tick();
      t = cyc;
      bus8.i_wr = 1'b0;
      compared++;
      if (bus8.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_after_write: o_busy=%b required 1", bus8.o_busy);
      end
      tick();
      compared++;
      if (bus8.o_set !== 8'b0000_0100) begin
         mismatched++;
         $display("[TB] FAIL set_latency: o_set=%b at edge %0d required 00000100", bus8.o_set, cyc - t);
      end
      compared++;
      if (bus8.o_gain !== 16'sd6) begin
         mismatched++;
         $display("[TB] FAIL issue_gain: o_gain=%0d required 6", bus8.o_gain);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         compared++;
         if (bus8.o_set !== 8'b0) begin
            mismatched++;
            $display("[TB] FAIL set_width: o_set=%b %0d cycles after issue required 0", bus8.o_set, k);
         end
         compared++;
         if (bus8.o_gain !== 16'sd6) begin
            mismatched++;
            $display("[TB] FAIL gain_hold: o_gain=%0d %0d cycles after issue required 6", bus8.o_gain, k);
         end
      end
      compared++;
      if (bus8.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_in_hold: o_busy=%b required 1", bus8.o_busy);
      end
      tick();
      compared++;
      if (bus8.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL busy_drop: o_busy=%b required 0", bus8.o_busy);
      end
   endtask

   task automatic test_clamp();
      int q;
      int base;
      doReset();
      bus8.i_next = 1'b1;
      tick();
      expectPulse(1, -100);
      expectPulse(5, 40);
      applyStimulus(5, 40);
      applyStimulus(1, -100);
      tick();
      compared++;
      if (bus8.o_set !== 8'b0 || bus8.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL clamp_wait: o_set=%b o_busy=%b required 0/1", bus8.o_set, bus8.o_busy);
      end
      base = pulseCount;
      bus8.i_next = 1'b0;
      q = cyc;
      waitPulses(base + 2, 20);
      if (pulseCount >= base + 2) begin
         compared++;
         if (pulseTimes[base] != q + 2) begin
            mismatched++;
            $display("[TB] FAIL clamp_first_time: pulse at edge %0d required %0d", pulseTimes[base], q + 2);
         end
         compared++;
         if (pulseTimes[base + 1] != q + 6) begin
            mismatched++;
            $display("[TB] FAIL clamp_second_time: pulse at edge %0d required %0d", pulseTimes[base + 1], q + 6);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      doReset();
      bus8.i_next = 1'b1;
      tick();
      for (int b = 0; b < 8; b++) begin
         applyStimulus(b, b * 5 - 17);
      end
      for (int b = 0; b < 8; b++) begin
         expectPulse(b, b * 5 - 17);
      end
      base = pulseCount;
      bus8.i_next = 1'b0;
      waitPulses(base + 8, 60);
      for (int b = 0; b < 8; b++) begin
         expectPulse(b, b * 5 - 17);
      end
      base = pulseCount;
      bus8.i_load_all = 1'b1;
      tick();
      bus8.i_load_all = 1'b0;
      waitPulses(base + 8, 60);
      if (pulseCount >= base + 8) begin
         for (int i = 1; i < 8; i++) begin
            compared++;
            if (pulseTimes[base + i] - pulseTimes[base + i - 1] != 4) begin
               mismatched++;
               $display("[TB] FAIL load_all_spacing: gap %0d between pulses %0d/%0d required 4",
                        pulseTimes[base + i] - pulseTimes[base + i - 1], i - 1, i);
            end
         end
      end
   endtask

   task automatic test_next_hold();
      int q;
      int base;
      waitIdle(40);
      bus8.i_next = 1'b1;
      tick();
      expectPulse(3, 7);
      applyStimulus(3, 7);
      base = pulseCount;
      repeat (10) tick();
      compared++;
      if (pulseCount != base || bus8.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL next_blocks: pulses=%0d o_busy=%b required %0d/1", pulseCount, bus8.o_busy, base);
      end
      bus8.i_next = 1'b0;
      q = cyc;
      waitPulses(base + 1, 10);
      if (pulseCount >= base + 1) begin
         compared++;
         if (pulseTimes[base] != q + 2) begin
            mismatched++;
            $display("[TB] FAIL next_release_time: pulse at edge %0d required %0d", pulseTimes[base], q + 2);
         end
      end
   endtask

   task automatic test_write_in_issue();
      int p;
      int base;
      waitIdle(40);
      base = pulseCount;
      expectPulse(4, 3);
      expectPulse(4, -5);
      bus8.i_wr      = 1'b1;
      bus8.i_wr_band = 3'd4;
      bus8.i_wr_gain = 16'sd3;
      tick();
      p = cyc;
      bus8.i_wr_gain = -16'sd5;
      tick();
      bus8.i_wr = 1'b0;
      waitPulses(base + 2, 20);
      if (pulseCount >= base + 2) begin
         compared++;
         if (pulseTimes[base] != p + 1) begin
            mismatched++;
            $display("[TB] FAIL reissue_first_time: edge %0d required %0d", pulseTimes[base], p + 1);
         end
         compared++;
         if (pulseTimes[base + 1] != p + 5) begin
            mismatched++;
            $display("[TB] FAIL reissue_second_time: edge %0d required %0d", pulseTimes[base + 1], p + 5);
         end
      end
   endtask

   task automatic test_ignore_band();
      waitIdle(40);
      bus6.i_wr      = 1'b1;
      bus6.i_wr_band = 3'd7;
      bus6.i_wr_gain = 16'sd5;
      tick();
      bus6.i_wr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         compared++;
         if (bus6.o_busy !== 1'b0 || bus6.o_set !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL ignore_band: o_busy=%b o_set=%b required 0/000000", bus6.o_busy, bus6.o_set);
         end
         tick();
      end
      bus6.i_wr      = 1'b1;
      bus6.i_wr_band = 3'd5;
      bus6.i_wr_gain = 16'sd20;
      tick();
      bus6.i_wr = 1'b0;
      tick();
      compared++;
      if (bus6.o_set !== 6'b10_0000) begin
         mismatched++;
         $display("[TB] FAIL top_band_set: o_set=%b required 100000", bus6.o_set);
      end
      compared++;
      if (bus6.o_gain !== 16'sd12) begin
         mismatched++;
         $display("[TB] FAIL top_band_gain: o_gain=%0d required 12", bus6.o_gain);
      end
   endtask

   task automatic checkOutput();
      int base;
      waitIdle(40);
      base = pulseCount;
      expectPulse(6, 9);
      applyStimulus(6, 9);
      waitPulses(base + 1, 10);
      rstN = 1'b0;
      #1;
      compared++;
      if (bus8.o_gain !== 16'sd0 || bus8.o_set !== 8'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_abort: o_gain=%0d o_set=%b required 0/0", bus8.o_gain, bus8.o_set);
      end
      compared++;
      if (bus8.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_abort_busy: o_busy=%b required 0", bus8.o_busy);
      end
      tick();
      tick();
      rstN = 1'b1;
      base = pulseCount;
      repeat (10) tick();
      compared++;
      if (pulseCount != base) begin
         mismatched++;
         $display("[TB] FAIL pulse_after_reset: %0d pulses required 0", pulseCount - base);
      end
   endtask

   initial begin
      rstN            = 1'b0;
      bus8.i_wr       = 1'b0;
      bus8.i_wr_band  = '0;
      bus8.i_wr_gain  = '0;
      bus8.i_load_all = 1'b0;
      bus8.i_next     = 1'b0;
      bus6.i_wr       = 1'b0;
      bus6.i_wr_band  = '0;
      bus6.i_wr_gain  = '0;
      bus6.i_load_all = 1'b0;
      bus6.i_next     = 1'b0;

      test_reset();
      test_single_write();
      test_clamp();
      test_back_to_back();
      test_next_hold();
      test_write_in_issue();
      test_ignore_band();
      checkOutput();

      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL pending_expectations: %0d left, required 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/eq_band_sequencer.md
Name: eq_band_sequencer

Overview:
- Owns the per-band gain table for the equalizer filter bank: NBAND biquad peaking sections, each with its own set strobe and a shared 16-bit gain bus.
- Accepts gain writes from the UI/control side, clamps them, and marks the band dirty.
- Issues set pulses one band at a time, round-robin, only between samples.
- Holds the gain bus stable long enough for a band to finish its internal 3-cycle coefficient computation.

Parameters:
- NBAND, 8, number of biquad bands sequenced.
- BW, 3, band index width, ceil(log2(NBAND)).
- GMAX, 12, clamp magnitude for gain in dB; the legal range is [-GMAX, +GMAX].
- SET_GAP, 3, cycles the gain bus is held after a set pulse before the next issue.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr  in  1  gain write strobe, one cycle per write.
- i_wr_band  in  BW  target band index for i_wr.
- i_wr_gain  in  16  signed gain in dB (integer).
- i_load_all  in  1  one-cycle pulse; marks every band dirty (re-push the whole table).
- i_next  in  1  sample strobe as seen by the bands; high means a sample is in flight.
- o_set  out  NBAND  one-hot set strobes, one per band.
- o_gain  out  16  shared signed gain bus to all bands.
- o_busy  out  1  high while any band is dirty or an issue/hold is in progress.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - gain table all 0; dirty all 0; round-robin pointer 0; state IDLE.
  - o_set 0; o_gain 0; o_busy 0.
  - Reset mid-issue aborts immediately with no further pulses. The bands' own reset state already corresponds to 0 dB.
- Write (i_wr=1):
  - Band index ≥ NBAND is ignored.
  - Otherwise store clamp(i_wr_gain) = max(-GMAX, min(GMAX, i_wr_gain)) with a signed compare, and set dirty[band].
  - Writes are accepted every cycle, including while busy.
  - Repeated writes to the same band before it issues collapse; the last value wins.
- i_load_all sets all dirty bits. It may coincide with i_wr; both take effect.
- State machine IDLE / ISSUE / HOLD:
  - IDLE: if any dirty bit is set and i_next=0, select the first dirty band k scanning upward from the pointer with wrap. Register o_gain=table[k] and o_set=onehot(k), clear dirty[k], go to ISSUE. If i_next=1, wait.
  - ISSUE: exactly one cycle with o_set[k]=1. Then o_set returns to 0; go to HOLD with counter=0.
  - HOLD: o_gain is held at table value k. Counter increments each cycle; at counter=SET_GAP-1 go to IDLE with pointer=(k+1) mod NBAND.
- Per-issue occupancy: 1 + SET_GAP cycles, so back-to-back issues are spaced 1+SET_GAP cycles apart.
- Latency:
  - A write at edge t to an idle block (i_next=0, nothing else dirty) produces o_set[k]=1 during the cycle following edge t+1.
  - That is, set is registered at edge t+1 and visible until edge t+2.
- Write to band k in the same cycle its dirty bit is being cleared by issue: the write wins. dirty[k] stays 1 and band k reissues later with the new value. The in-flight pulse carries the old latched value.
- i_next rising during ISSUE/HOLD does not abort. A set is never started while i_next=1.
- o_gain changes only at entry to ISSUE. o_set has at most one bit high at any time.
- o_busy = (|dirty) | (state != IDLE), registered.

Test Plan:
- Reset, then write band 2 gain +6 with i_next=0 → o_set=8'b0000_0100 for exactly one cycle, 2 edges after the write; o_gain=+6 held for 4 cycles; o_busy then drops.
- Write band 5 gain +40, then band 1 gain -100 → o_gain=+12 and -12 respectively (clamped); band 1 issues first from pointer 0, then band 5.
- i_load_all after writing all bands → 8 set pulses in order 0..7, spaced 4 cycles apart, each carrying its table value.
- Hold i_next=1 while band 3 is dirty → no o_set activity. Drop i_next → set pulse for band 3 on the 2nd edge after the drop.
- Write band 4 = +3, then write band 4 = -5 in its issue cycle → first pulse carries +3, second pulse for band 4 carries -5.
- Write i_wr_band=7 with NBAND=6 → ignored, o_busy stays 0. Assert i_rst_n low during HOLD → o_set=0 and o_gain=0 immediately; no pulses after release.
